dot_prod_feeder: RTL and testbench
==================================

# dot_prod_feeder

Operand responder for the column-serial matrix-vector engine `dot_prod`. It holds the NROW×NCOL weight matrix and a ping-pong buffered input vector, and answers the engine's `colAddress` with the matching weight column (`weightRow`) and input element (`inputVector`). The next timestep's vector loads through a valid/ready write port while the current one is consumed. Banks swap on the engine's `dataReady` pulse. It sits between the layer controller/DMA and `dot_prod` in each RNN gate datapath.

## Interface
- NROW, 16, rows of the weight matrix (elements per `weightRow`)
- NCOL, 16, columns of the matrix, which is also the input vector length
- QN, 6, integer bits of the Q-format
- QM, 11, fractional bits of the Q-format
- Derived constants:
  - BITWIDTH = QN+QM+1
  - ADDR_BITWIDTH = clog2(NCOL)
  - LAYER_BITWIDTH = BITWIDTH*NROW
- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; state is cleared on a rising clk edge while reset==0
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid&&wr_ready at the clock edge
- wr_sel  in  1  write target: 0 = weight column, 1 = input element (shadow bank)
- wr_addr  in  ADDR_BITWIDTH  column index
- wr_data  in  LAYER_BITWIDTH  weight column payload; for input writes only [BITWIDTH-1:0] is used
- wr_last  in  1  with an accepted input write, marks the shadow vector complete
- colAddress  in  ADDR_BITWIDTH  read address from `dot_prod`
- dataReady  in  1  end-of-pass pulse from `dot_prod`
- weightRow  out  LAYER_BITWIDTH  weight column `colAddress`; element r is at [r*BITWIDTH +: BITWIDTH]
- inputVector  out  BITWIDTH  element `colAddress` of the active input bank
- active_valid  out  1  the active bank holds a complete vector
- shadow_full  out  1  the shadow bank is complete and waiting to swap
- pass_count  out  16  number of completed passes on valid data

## Operation
- Storage:
  - One weight bank of NCOL entries × LAYER_BITWIDTH.
  - Two input banks of NCOL entries × BITWIDTH each.
  - `bank_sel` selects which input bank is active; the other is the shadow.
- Weight writes:
  - wr_ready is 1 for wr_sel=0 in every non-reset cycle.
  - Weights may be written at any time. Coherency during a pass is the controller's responsibility.
- Input writes:
  - wr_ready = !shadow_full. Writes go to the shadow bank only.
  - An accepted write with wr_last=1 sets shadow_full.
- Out-of-range writes: a write with wr_addr ≥ NCOL is accepted and dropped (no storage change). A wr_last on such a write still sets shadow_full.
- Read path (combinational):
  - weightRow = wbank[colAddress].
  - inputVector = active_valid ? ibank[bank_sel][colAddress] : 0.
  - The engine therefore accumulates zeros until the first vector arrives.
- Swap FSM, two states:
  - EMPTY (active_valid=0):
    - If shadow_full: toggle bank_sel, set active_valid, clear shadow_full, and go to RUN. No dataReady is required.
  - RUN (active_valid=1):
    - On dataReady==1: pass_count increments, wrapping at 2^16.
    - If dataReady==1 and shadow_full==1: also toggle bank_sel and clear shadow_full.
    - active_valid never falls except on reset.
- Swap uses the registered shadow_full. If a wr_last write and dataReady occur in the same cycle, that dataReady does not swap; the swap happens on the next pass's dataReady.
- No arithmetic beyond the counter. Data passes bit-exact; signedness is preserved by raw bit copy.

## Timing
- Reset values:
  - wr_ready=0 while reset==0, then 1 from the first cycle after release.
  - active_valid=0, shadow_full=0, bank_sel=0, pass_count=0.
  - inputVector=0.
  - weightRow reflects the unreset weight storage; it is undefined until written.
- Storage arrays are not reset.
- Write-to-read latency is 1 cycle: data written at edge k is visible on the outputs after edge k.
- Swap at edge k: from cycle k+1 inputVector reads the new bank. This lines up with `dot_prod` re-entering CALC at colAddress=0 after END.
- Reset mid-operation: all state returns to reset values on that edge. A partially loaded shadow is discarded.

## Structure
- Shared package `rnn_fixed_pkg`:
  - QN, QM, BITWIDTH, LAYER_BITWIDTH.
  - clog2 helper.
  - Swap-FSM state encoding (EMPTY=1'b0, RUN=1'b1).
- Sub-module `operand_bank`: parameterized DEPTH×WIDTH register array with one synchronous write port, one asynchronous read port, and an out-of-range write guard.
  - Used three times: the weight bank and the two input banks.

## Test plan
- Reset with reset=0 for 2 cycles, then release: wr_ready=0 during reset, then 1. active_valid=0, shadow_full=0, pass_count=0, inputVector=0.
- Write input elements 0..15 with values 1..16 (Q-format raw), wr_last on element 15: shadow_full=1 after the last edge, and one cycle later active_valid=1, shadow_full=0. colAddress=5 gives inputVector=6.
- Write weight column 3 = {r*256+3}, then set colAddress=3: the next cycle weightRow element r equals r*256+3 for every r. An input write attempted while shadow_full=1 sees wr_ready=0 and does not change the stored vector.
- Load a second vector (all 0x3FFFF) while running, then pulse dataReady: bank swaps on that edge, inputVector=0x3FFFF from the next cycle, and pass_count increments by 1.
- wr_last accepted in the same cycle as dataReady: no swap on that edge, shadow_full=1. The swap occurs at the next dataReady.
- Assert reset mid-load (after 7 shadow writes): active_valid=0 and shadow_full=0. A fresh 16-element load then completes normally.

Source files
------------

// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point constants, clog2 helper and swap-FSM encoding for the RNN gate datapath.
package rnn_fixed_pkg;

  localparam int QN             = 6;
  localparam int QM             = 11;
  localparam int BITWIDTH       = QN + QM + 1;
  localparam int LAYER_BITWIDTH = BITWIDTH * 16;

  // Never returns less than 1 so a one-entry array still gets a usable address port.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } swap_state_e;

endpackage

// File: rtl/operand_bank.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module operand_bank
  import rnn_fixed_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BITWIDTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << AW)) begin : g_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_partial
      assign wr_in_range = (int'(wr_addr) < DEPTH);
      assign rd_in_range = (int'(rd_addr) < DEPTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_in_range ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/dot_prod_feeder.sv
// Weight/input operand responder for dot_prod: one weight bank, ping-pong input banks
// swapped on the engine's end-of-pass pulse.
module dot_prod_feeder #(
  parameter int NROW = 16,
  parameter int NCOL = 16,
  parameter int QN   = rnn_fixed_pkg::QN,
  parameter int QM   = rnn_fixed_pkg::QM,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int ADDR_BITWIDTH  = rnn_fixed_pkg::clog2(NCOL),
  localparam int LAYER_BITWIDTH = BITWIDTH * NROW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      wr_sel,
  input  logic [ADDR_BITWIDTH-1:0]  wr_addr,
  input  logic [LAYER_BITWIDTH-1:0] wr_data,
  input  logic                      wr_last,
  input  logic [ADDR_BITWIDTH-1:0]  colAddress,
  input  logic                      dataReady,
  output logic [LAYER_BITWIDTH-1:0] weightRow,
  output logic [BITWIDTH-1:0]       inputVector,
  output logic                      active_valid,
  output logic                      shadow_full,
  output logic [15:0]               pass_count
);

  import rnn_fixed_pkg::swap_state_e;
  import rnn_fixed_pkg::EMPTY;
  import rnn_fixed_pkg::RUN;

  swap_state_e         state_q;
  logic                bank_sel_q;
  logic                shadow_full_q;
  logic [15:0]         pass_count_q;
  logic [15:0]         pass_count_d;

  logic                wr_fire;
  logic                wgt_we;
  logic                in_we0;
  logic                in_we1;
  logic                last_fire;
  logic [BITWIDTH-1:0] ivec0;
  logic [BITWIDTH-1:0] ivec1;

  // Input writes stall only while a completed shadow vector waits to swap.
  assign wr_ready  = reset && (!wr_sel || !shadow_full_q);
  assign wr_fire   = wr_valid && wr_ready;
  assign wgt_we    = wr_fire && !wr_sel;
  assign in_we0    = wr_fire && wr_sel && bank_sel_q;
  assign in_we1    = wr_fire && wr_sel && !bank_sel_q;
  assign last_fire = wr_fire && wr_sel && wr_last;

  operand_bank #(.DEPTH(NCOL), .WIDTH(LAYER_BITWIDTH)) u_wbank (
    .clk     (clk),
    .wr_en   (wgt_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (colAddress),
    .rd_data (weightRow)
  );

  operand_bank #(.DEPTH(NCOL), .WIDTH(BITWIDTH)) u_ibank0 (
    .clk     (clk),
    .wr_en   (in_we0),
    .wr_addr (wr_addr),
    .wr_data (wr_data[BITWIDTH-1:0]),
    .rd_addr (colAddress),
    .rd_data (ivec0)
  );

  operand_bank #(.DEPTH(NCOL), .WIDTH(BITWIDTH)) u_ibank1 (
    .clk     (clk),
    .wr_en   (in_we1),
    .wr_addr (wr_addr),
    .wr_data (wr_data[BITWIDTH-1:0]),
    .rd_addr (colAddress),
    .rd_data (ivec1)
  );

  assign pass_count_d = pass_count_q + 16'd1;

  // Swap decisions look at the registered shadow_full, so a wr_last landing with
  // dataReady on the same edge waits for the following pass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= EMPTY;
      bank_sel_q    <= 1'b0;
      shadow_full_q <= 1'b0;
      pass_count_q  <= '0;
    end else begin
      if (last_fire) begin
        shadow_full_q <= 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (shadow_full_q) begin
            bank_sel_q    <= !bank_sel_q;
            shadow_full_q <= 1'b0;
            state_q       <= RUN;
          end
        end
        RUN: begin
          if (dataReady) begin
            pass_count_q <= pass_count_d;
            if (shadow_full_q) begin
              bank_sel_q    <= !bank_sel_q;
              shadow_full_q <= 1'b0;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign active_valid = (state_q == RUN);
  assign shadow_full  = shadow_full_q;
  assign pass_count   = pass_count_q;
  assign inputVector  = active_valid ? (bank_sel_q ? ivec1 : ivec0) : '0;

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Scoreboard bench for dot_prod_feeder: driver pushes expected outputs from a vector-level model,
// monitor pops and compares mid-cycle.
module tb_dot_prod_feeder;

  localparam int NROW = 16;
  localparam int NCOL = 16;
  localparam int BW   = 18;
  localparam int LW   = BW * NROW;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic          wr_last;
  logic [AW-1:0] colAddress;
  logic          dataReady;
  logic [LW-1:0] weightRow;
  logic [BW-1:0] inputVector;
  logic          active_valid;
  logic          shadow_full;
  logic [15:0]   pass_count;

  always #5 clk = ~clk;

  dot_prod_feeder #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .colAddress   (colAddress),
    .dataReady    (dataReady),
    .weightRow    (weightRow),
    .inputVector  (inputVector),
    .active_valid (active_valid),
    .shadow_full  (shadow_full),
    .pass_count   (pass_count)
  );

  typedef struct {
    bit            rdy;
    bit            av;
    bit            sf;
    logic [15:0]   pc;
    logic [BW-1:0] iv;
    bit            iv_known;
    logic [LW-1:0] wrow;
    bit            wrow_known;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: whole vectors, swapped as units; per-element "known" flags.
  logic [LW-1:0] m_w    [NCOL];
  bit            m_wk   [NCOL];
  logic [BW-1:0] m_act  [NCOL];
  bit            m_actk [NCOL];
  logic [BW-1:0] m_sh   [NCOL];
  bit            m_shk  [NCOL];
  bit            m_av;
  bit            m_sf;
  bit            m_known;
  logic [15:0]   m_pc;

  function automatic bit m_ready();
    return reset && (!wr_sel || !m_sf);
  endfunction

  function automatic logic [LW-1:0] rand_layer();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.rdy        = m_ready();
    e.av         = m_av;
    e.sf         = m_sf;
    e.pc         = m_pc;
    e.iv_known   = !m_av || m_actk[colAddress];
    e.iv         = m_av ? m_act[colAddress] : '0;
    e.wrow_known = m_wk[colAddress];
    e.wrow       = m_w[colAddress];
    sbq.push_back(e);
  endtask

  task automatic model_edge();
    bit            fire;
    bit            sf_old;
    bit            do_swap;
    bit            do_cnt;
    logic [BW-1:0] tv [NCOL];
    bit            tk [NCOL];
    if (!reset) begin
      m_known = 1'b1;
      m_av    = 1'b0;
      m_sf    = 1'b0;
      m_pc    = '0;
      for (int i = 0; i < NCOL; i++) begin
        m_actk[i] = 1'b0;
        m_shk[i]  = 1'b0;
      end
      return;
    end
    fire    = wr_valid && m_ready();
    sf_old  = m_sf;
    do_swap = sf_old && (!m_av || dataReady);
    do_cnt  = m_av && dataReady;
    if (fire && !wr_sel) begin
      m_w[wr_addr]  = wr_data;
      m_wk[wr_addr] = 1'b1;
    end
    if (fire && wr_sel) begin
      m_sh[wr_addr]  = wr_data[BW-1:0];
      m_shk[wr_addr] = 1'b1;
      if (wr_last) m_sf = 1'b1;
    end
    if (do_swap) begin
      tv = m_act;  m_act  = m_sh;  m_sh  = tv;
      tk = m_actk; m_actk = m_shk; m_shk = tk;
      m_sf = 1'b0;
      m_av = 1'b1;
    end
    if (do_cnt) m_pc = m_pc + 16'd1;
  endtask

  task automatic tick();
    if (m_known) push_expected();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_valid   = 1'b0;
    wr_sel     = 1'b0;
    wr_last    = 1'b0;
    wr_addr    = '0;
    wr_data    = rand_layer();
    dataReady  = 1'b0;
    colAddress = AW'($urandom_range(0, NCOL - 1));
  endtask

  task automatic wr_input(input int addr, input logic [BW-1:0] v, input bit last, input bit dr);
    idle();
    wr_valid  = 1'b1;
    wr_sel    = 1'b1;
    wr_addr   = AW'(addr);
    wr_data[BW-1:0] = v;
    wr_last   = last;
    dataReady = dr;
    tick();
  endtask

  task automatic wr_weight(input int addr, input logic [LW-1:0] d);
    idle();
    wr_valid = 1'b1;
    wr_sel   = 1'b0;
    wr_addr  = AW'(addr);
    wr_data  = d;
    tick();
  endtask

  task automatic sweep();
    for (int c = 0; c < NCOL; c++) begin
      idle();
      colAddress = AW'(c);
      tick();
    end
  endtask

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("wr_ready", LW'(wr_ready), LW'(e.rdy));
        chk("active_valid", LW'(active_valid), LW'(e.av));
        chk("shadow_full", LW'(shadow_full), LW'(e.sf));
        chk("pass_count", LW'(pass_count), LW'(e.pc));
        if (e.iv_known) chk("inputVector", LW'(inputVector), LW'(e.iv));
        if (e.wrow_known) chk("weightRow", weightRow, e.wrow);
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : driver
    logic [LW-1:0] col3;
    int            load_idx;
    bit            accepted;
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;

    // First vector 1..16, then hold idle while the EMPTY-state swap happens.
    for (int i = 0; i < NCOL; i++) wr_input(i, BW'(i + 1), i == NCOL - 1, 1'b0);
    idle(); tick();
    idle(); colAddress = AW'(5); tick();

    for (int c = 0; c < NCOL; c++) wr_weight(c, rand_layer());
    for (int r = 0; r < NROW; r++) col3[r*BW +: BW] = BW'(r * 256 + 3);
    wr_weight(3, col3);
    idle(); colAddress = AW'(3); tick();

    // Second vector of all ones fills the shadow; a further write must bounce.
    for (int i = 0; i < NCOL; i++) wr_input(i, 18'h3FFFF, i == NCOL - 1, 1'b0);
    wr_input(2, 18'h12345, 1'b0, 1'b0);
    idle(); dataReady = 1'b1; tick();
    sweep();

    // wr_last coinciding with dataReady must defer the swap by one pass.
    for (int i = 0; i < NCOL - 1; i++) wr_input(i, BW'($urandom), 1'b0, 1'b0);
    wr_input(NCOL - 1, BW'($urandom), 1'b1, 1'b1);
    idle(); tick();
    idle(); dataReady = 1'b1; tick();
    sweep();

    // Reset in the middle of a shadow load, then a clean reload.
    for (int i = 0; i < 7; i++) wr_input(i, BW'($urandom), 1'b0, 1'b0);
    idle(); reset = 1'b0; tick();
    reset = 1'b1;
    idle(); tick();
    for (int i = 0; i < NCOL; i++) wr_input(i, BW'($urandom), i == NCOL - 1, 1'b0);
    idle(); tick();
    sweep();

    load_idx = 0;
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset    = ($urandom_range(0, 199) != 0);
      wr_valid = $urandom_range(0, 1) != 0;
      wr_sel   = $urandom_range(0, 2) != 0;
      if (wr_sel) begin
        wr_addr = AW'(load_idx);
        wr_last = (load_idx == NCOL - 1);
      end else begin
        wr_addr = AW'($urandom_range(0, NCOL - 1));
      end
      dataReady = ($urandom_range(0, 9) == 0);
      accepted  = wr_valid && wr_sel && m_ready();
      if (!reset) load_idx = 0;
      else if (accepted) load_idx = (load_idx + 1) % NCOL;
      tick();
    end

    idle();
    tick();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
